// File: rtl/frame_gen.sv
// ============================================================================
// Module   : frame_gen
// Purpose  : Ethernet test-frame generator for the MAC TX byte interface.
//            Builds frames on the fly from a parameterised header, a 32-bit
//            sequence number and a selectable payload pattern. Frame length,
//            inter-frame gap and frames per burst are latched at start.
// Ports    : tx_clk, reset_n          clock / async active-low reset
//            start, stop               burst control pulses
//            cfg_len/ifg/count/mode    burst configuration (latched at start)
//            conf_tx_*                 static MAC configuration outputs
//            mac_tx_data/dvld/ack      MAC TX byte interface
//            frame_sent, done, busy    status pulses / level
//            frames_sent               free-running frame counter (wraps)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_gen #(
   parameter logic [47:0] DST_MAC  = 48'hFFFFFFFFFFFF,
   parameter logic [47:0] SRC_MAC  = 48'h0012E228130E,
   parameter logic [15:0] ETH_TYPE = 16'h88B5,
   parameter int          JUMBO    = 0
) (
   input  logic        tx_clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        stop,
   input  logic [13:0] cfg_len,
   input  logic [15:0] cfg_ifg,
   input  logic [15:0] cfg_count,
   input  logic [1:0]  cfg_mode,
   output logic        conf_tx_en,
   output logic        conf_tx_jumbo_en,
   output logic        conf_tx_no_gen_crc,
   output logic [7:0]  mac_tx_data,
   output logic        mac_tx_dvld,
   input  logic        mac_tx_ack,
   output logic        frame_sent,
   output logic        busy,
   output logic        done,
   output logic [31:0] frames_sent
);

   localparam logic [13:0] MIN_LEN = 14'd60;
   localparam logic [13:0] MAX_LEN = (JUMBO != 0) ? 14'd9014 : 14'd1514;
   localparam logic [13:0] PAY_IDX = 14'd18;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_ACK = 2'd1,
      S_DATA     = 2'd2,
      S_IFG      = 2'd3
   } state_t;

   state_t      state;
   logic [13:0] len_q;
   logic [13:0] idx;         // index of the byte currently on mac_tx_data
   logic [15:0] ifg_q;
   logic [15:0] ifg_cnt;
   logic [15:0] count_q;
   logic [15:0] burst_cnt;
   logic [1:0]  mode_q;
   logic [31:0] seq;
   logic [7:0]  lfsr;
   logic        stop_pend;

   logic [13:0] nidx;
   logic [143:0] hdr;
   logic [7:0]  hpos;
   logic [7:0]  lfsr_cur;
   logic [7:0]  lfsr_adv;
   logic [7:0]  pay_off;
   logic [7:0]  nbyte;
   logic        last;
   logic        burst_end;
   logic [13:0] len_clamped;
   logic [15:0] ifg_eff;

   assign conf_tx_no_gen_crc = 1'b0;

   // Next-byte generator: everything here describes the byte that will be
   // registered onto mac_tx_data at the coming edge (index nidx).
   always_comb begin
      nidx     = (state == S_DATA) ? idx + 14'd1 : 14'd1;
      hdr      = {DST_MAC, SRC_MAC, ETH_TYPE, seq};
      hpos     = 8'd143 - {nidx[4:0], 3'b000};
      // LFSR is reseeded at the first payload byte so every frame repeats
      lfsr_cur = (nidx == PAY_IDX) ? 8'hFF : lfsr;
      // Fibonacci x^8+x^6+x^5+x^4+1, shifting toward the MSB
      lfsr_adv = {lfsr_cur[6:0], lfsr_cur[7] ^ lfsr_cur[5] ^ lfsr_cur[4] ^ lfsr_cur[3]};
      // (i-18) mod 256 depends only on the low byte of i
      pay_off  = nidx[7:0] - 8'd18;
      nbyte    = 8'h00;
      if (nidx < PAY_IDX) begin
         nbyte = hdr[hpos -: 8];
      end else begin
         case (mode_q)
            2'd1:    nbyte = pay_off;
            2'd2:    nbyte = lfsr_cur;
            default: nbyte = 8'h00;
         endcase
      end
      last        = (idx == len_q - 14'd1);
      burst_end   = stop | stop_pend |
                    ((count_q != 16'd0) && (burst_cnt + 16'd1 == count_q));
      len_clamped = (cfg_len < MIN_LEN) ? MIN_LEN :
                    (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
      ifg_eff     = (cfg_ifg == 16'd0) ? 16'd1 : cfg_ifg;
   end

   always_ff @(posedge tx_clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= S_IDLE;
         len_q            <= 14'd0;
         idx              <= 14'd0;
         ifg_q            <= 16'd0;
         ifg_cnt          <= 16'd0;
         count_q          <= 16'd0;
         burst_cnt        <= 16'd0;
         mode_q           <= 2'd0;
         seq              <= 32'd0;
         lfsr             <= 8'd0;
         stop_pend        <= 1'b0;
         conf_tx_en       <= 1'b0;
         conf_tx_jumbo_en <= 1'b0;
         mac_tx_data      <= 8'd0;
         mac_tx_dvld      <= 1'b0;
         frame_sent       <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         frames_sent      <= 32'd0;
      end else begin
         conf_tx_en       <= 1'b1;
         conf_tx_jumbo_en <= (JUMBO != 0);
         frame_sent       <= 1'b0;
         done             <= 1'b0;
         case (state)
            S_IDLE: begin
               // start has priority; a stop in the same cycle is dropped
               if (start) begin
                  len_q       <= len_clamped;
                  ifg_q       <= ifg_eff;
                  count_q     <= cfg_count;
                  mode_q      <= cfg_mode;
                  seq         <= 32'd0;
                  burst_cnt   <= 16'd0;
                  stop_pend   <= 1'b0;
                  busy        <= 1'b1;
                  mac_tx_dvld <= 1'b1;
                  mac_tx_data <= DST_MAC[47:40];
                  state       <= S_WAIT_ACK;
               end
            end
            S_WAIT_ACK: begin
               if (stop) stop_pend <= 1'b1;
               if (mac_tx_ack) begin
                  idx         <= nidx;
                  mac_tx_data <= nbyte;
                  lfsr        <= lfsr_adv;
                  state       <= S_DATA;
               end
            end
            S_DATA: begin
               if (stop) stop_pend <= 1'b1;
               if (last) begin
                  mac_tx_dvld <= 1'b0;
                  mac_tx_data <= 8'd0;
                  frame_sent  <= 1'b1;
                  seq         <= seq + 32'd1;
                  frames_sent <= frames_sent + 32'd1;
                  burst_cnt   <= burst_cnt + 16'd1;
                  if (burst_end) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     ifg_cnt <= ifg_q - 16'd1;
                     state   <= S_IFG;
                  end
               end else begin
                  idx         <= nidx;
                  mac_tx_data <= nbyte;
                  lfsr        <= lfsr_adv;
               end
            end
            S_IFG: begin
               if (stop || stop_pend) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_IDLE;
               end else if (ifg_cnt == 16'd0) begin
                  mac_tx_dvld <= 1'b1;
                  mac_tx_data <= DST_MAC[47:40];
                  state       <= S_WAIT_ACK;
               end else begin
                  ifg_cnt <= ifg_cnt - 16'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_frame_gen.sv
// ============================================================================
// Module   : tb_frame_gen
// Purpose  : Self-checking bench for frame_gen. Expected bytes are queued when
//            a burst is launched and compared against bytes collected from
//            the MAC TX interface.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_frame_gen;

   localparam logic [47:0] C_DST  = 48'hFFFFFFFFFFFF;
   localparam logic [47:0] C_SRC  = 48'h0012E228130E;
   localparam logic [15:0] C_TYPE = 16'h88B5;

   logic        tx_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [13:0] cfg_len = 14'd0;
   logic [15:0] cfg_ifg = 16'd0;
   logic [15:0] cfg_count = 16'd0;
   logic [1:0]  cfg_mode = 2'd0;
   logic        conf_tx_en, conf_tx_jumbo_en, conf_tx_no_gen_crc;
   logic [7:0]  mac_tx_data;
   logic        mac_tx_dvld;
   logic        mac_tx_ack = 1'b0;
   logic        frame_sent, busy, done;
   logic [31:0] frames_sent;

   int errors = 0;
   int checks = 0;

   // scoreboard and monitor records
   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   int hi_q[$], fall_q[$], gap_q[$], wait_q[$], fs_q[$], dn_q[$];
   int cyc = 0, hi_cnt = 0, low_cnt = 0, wcnt = 0, hold_bad = 0;
   bit prev_dvld = 0, waiting = 0, gap_armed = 0, ack_next = 0;
   logic [7:0] hold_val = 8'h00;
   int hold_target = 1;
   bit ack_always = 0;

   frame_gen #(
      .DST_MAC(C_DST), .SRC_MAC(C_SRC), .ETH_TYPE(C_TYPE), .JUMBO(0)
   ) dut (
      .tx_clk(tx_clk), .reset_n(reset_n), .start(start), .stop(stop),
      .cfg_len(cfg_len), .cfg_ifg(cfg_ifg), .cfg_count(cfg_count), .cfg_mode(cfg_mode),
      .conf_tx_en(conf_tx_en), .conf_tx_jumbo_en(conf_tx_jumbo_en),
      .conf_tx_no_gen_crc(conf_tx_no_gen_crc),
      .mac_tx_data(mac_tx_data), .mac_tx_dvld(mac_tx_dvld), .mac_tx_ack(mac_tx_ack),
      .frame_sent(frame_sent), .busy(busy), .done(done), .frames_sent(frames_sent)
   );

   always #5 tx_clk = ~tx_clk;

   // Monitor / MAC model: collects bytes, gap lengths, pulses; drives ack.
   initial forever begin
      @(negedge tx_clk);
      cyc++;
      ack_next = ack_always;
      if (frame_sent) fs_q.push_back(cyc);
      if (done) dn_q.push_back(cyc);
      if (mac_tx_dvld) begin
         if (!prev_dvld) begin
            if (gap_armed) gap_q.push_back(low_cnt);
            gap_armed = 0; waiting = 1; wcnt = 0; hi_cnt = 0;
            hold_val = mac_tx_data;
            rx_q.push_back(mac_tx_data);
         end else if (!waiting) begin
            rx_q.push_back(mac_tx_data);
         end else if (mac_tx_data !== hold_val) begin
            hold_bad++;
         end
         hi_cnt++;
         if (waiting) begin
            wcnt++;
            if (wcnt >= hold_target) begin
               ack_next = 1'b1; waiting = 0; wait_q.push_back(wcnt);
            end else begin
               ack_next = 1'b0;
            end
         end
      end else begin
         if (prev_dvld) begin
            hi_q.push_back(hi_cnt); fall_q.push_back(cyc);
            low_cnt = 0; gap_armed = busy;
         end
         low_cnt++;
      end
      prev_dvld = mac_tx_dvld;
      mac_tx_ack = ack_next;
   end

   // Reference frame model
   task automatic push_frame(input int len, input logic [31:0] sq, input logic [1:0] md);
      logic [143:0] h;
      logic [7:0] lf, b;
      h  = {C_DST, C_SRC, C_TYPE, sq};
      lf = 8'hFF;
      for (int i = 0; i < len; i++) begin
         if (i < 18) b = h[143 - 8*i -: 8];
         else if (md == 2'd1) b = 8'((i - 18) % 256);
         else if (md == 2'd2) begin
            b  = lf;
            lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
         end else b = 8'h00;
         exp_q.push_back(b);
      end
   endtask

   task automatic kick(input int len, input int ifg, input int cnt, input logic [1:0] md,
                       input bit with_stop);
      @(negedge tx_clk);
      cfg_len = 14'(len); cfg_ifg = 16'(ifg); cfg_count = 16'(cnt); cfg_mode = md;
      start = 1'b1; stop = with_stop;
      @(negedge tx_clk);
      start = 1'b0; stop = 1'b0;
   endtask

   task automatic wait_done(input int base, input int limit, output bit ok);
      for (int i = 0; i < limit && dn_q.size() <= base; i++) @(negedge tx_clk);
      ok = (dn_q.size() > base);
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) @(negedge tx_clk);
      checks++;
      if ({conf_tx_en, conf_tx_jumbo_en, conf_tx_no_gen_crc, mac_tx_dvld, frame_sent, busy, done} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 0000000",
                  {conf_tx_en, conf_tx_jumbo_en, conf_tx_no_gen_crc, mac_tx_dvld, frame_sent, busy, done});
      end
      checks++;
      if (mac_tx_data !== 8'h00 || frames_sent !== 32'd0) begin
         errors++;
         $display("FAIL reset_data: got data=%h frames=%0d expected 00/0", mac_tx_data, frames_sent);
      end
      reset_n = 1'b1;
      #1;
      checks++;
      if (conf_tx_en !== 1'b0) begin
         errors++; $display("FAIL tx_en_before_edge: got %b expected 0", conf_tx_en);
      end
      @(negedge tx_clk);
      checks++;
      if (conf_tx_en !== 1'b1 || conf_tx_jumbo_en !== 1'b0 || conf_tx_no_gen_crc !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL conf_after_reset: got en=%b jumbo=%b nocrc=%b busy=%b expected 1 0 0 0",
                  conf_tx_en, conf_tx_jumbo_en, conf_tx_no_gen_crc, busy);
      end
   endtask

   task automatic test_basic;
      int rb, hb, fb, db, lb, n, first;
      bit ok;
      logic [7:0] e, got, exp_b;
      hold_target = 1; ack_always = 1;
      rb = rx_q.size(); hb = hi_q.size(); fb = fs_q.size(); db = dn_q.size(); lb = fall_q.size();
      push_frame(60, 32'd0, 2'd1);
      kick(60, 1, 1, 2'd1, 0);
      checks++;
      if (busy !== 1'b1 || mac_tx_dvld !== 1'b1 || mac_tx_data !== 8'hFF) begin
         errors++;
         $display("FAIL start_latency: got busy=%b dvld=%b data=%h expected 1 1 ff", busy, mac_tx_dvld, mac_tx_data);
      end
      wait_done(db, 300, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
      n = 0; first = -1; got = 8'h00; exp_b = 8'h00;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (first < 0 && (rb + n >= rx_q.size() || rx_q[rb + n] !== e)) begin
            first = n; exp_b = e; got = (rb + n < rx_q.size()) ? rx_q[rb + n] : 8'h00;
         end
         n++;
      end
      checks++;
      if (first >= 0 || rx_q.size() - rb != n) begin
         errors++;
         $display("FAIL basic_bytes: byte %0d got %h expected %h (count %0d vs %0d)", first, got, exp_b, rx_q.size() - rb, n);
      end
      checks++;
      if (hi_q.size() <= hb || hi_q[hb] != 60) begin
         errors++; $display("FAIL basic_dvld_len: got %0d expected 60", (hi_q.size() > hb) ? hi_q[hb] : -1);
      end
      checks++;
      if (fs_q.size() <= fb || dn_q.size() <= db || fall_q.size() <= lb ||
          fs_q[fb] != dn_q[db] || fs_q[fb] != fall_q[lb]) begin
         errors++; $display("FAIL basic_pulse_align: got frame_sent/done/dvld-fall not on one cycle expected same cycle");
      end
      checks++;
      if (frames_sent !== 32'd1 || busy !== 1'b0) begin
         errors++; $display("FAIL basic_count: got frames=%0d busy=%b expected 1 0", frames_sent, busy);
      end
   endtask

   task automatic test_ack_delay;
      int rb, hb, wb, db, hbad, n, first;
      bit ok;
      logic [7:0] e, got, exp_b;
      hold_target = 7; ack_always = 0;
      rb = rx_q.size(); hb = hi_q.size(); wb = wait_q.size(); db = dn_q.size(); hbad = hold_bad;
      push_frame(64, 32'd0, 2'd0);
      kick(64, 3, 1, 2'd0, 0);
      wait_done(db, 300, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL ackdly_timeout: got no done expected done"); end
      n = 0; first = -1; got = 8'h00; exp_b = 8'h00;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (first < 0 && (rb + n >= rx_q.size() || rx_q[rb + n] !== e)) begin
            first = n; exp_b = e; got = (rb + n < rx_q.size()) ? rx_q[rb + n] : 8'h00;
         end
         n++;
      end
      checks++;
      if (first >= 0 || rx_q.size() - rb != n) begin
         errors++;
         $display("FAIL ackdly_bytes: byte %0d got %h expected %h (count %0d vs %0d)", first, got, exp_b, rx_q.size() - rb, n);
      end
      checks++;
      if (wait_q.size() <= wb || wait_q[wb] != 7 || hold_bad != hbad) begin
         errors++; $display("FAIL ackdly_hold: got hold=%0d unstable=%0d expected 7 0",
                            (wait_q.size() > wb) ? wait_q[wb] : -1, hold_bad - hbad);
      end
      checks++;
      if (hi_q.size() <= hb || hi_q[hb] != 70) begin
         errors++; $display("FAIL ackdly_dvld_len: got %0d expected 70", (hi_q.size() > hb) ? hi_q[hb] : -1);
      end
      checks++;
      if (frames_sent !== 32'd2) begin
         errors++; $display("FAIL ackdly_count: got %0d expected 2", frames_sent);
      end
   endtask

   task automatic test_lfsr_burst;
      int rb, gb, fb, db, n, first;
      bit ok;
      logic [7:0] e, got, exp_b;
      logic [7:0] c_lfsr [6];
      c_lfsr = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};
      hold_target = 1; ack_always = 0;
      rb = rx_q.size(); gb = gap_q.size(); fb = fs_q.size(); db = dn_q.size();
      for (int f = 0; f < 3; f++) push_frame(80, 32'(f), 2'd2);
      kick(80, 12, 3, 2'd2, 0);
      wait_done(db, 800, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL lfsr_timeout: got no done expected done"); end
      n = 0; first = -1; got = 8'h00; exp_b = 8'h00;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (first < 0 && (rb + n >= rx_q.size() || rx_q[rb + n] !== e)) begin
            first = n; exp_b = e; got = (rb + n < rx_q.size()) ? rx_q[rb + n] : 8'h00;
         end
         n++;
      end
      checks++;
      if (first >= 0 || rx_q.size() - rb != n) begin
         errors++;
         $display("FAIL lfsr_bytes: byte %0d got %h expected %h (count %0d vs %0d)", first, got, exp_b, rx_q.size() - rb, n);
      end
      first = -1;
      for (int i = 0; i < 6; i++)
         if (first < 0 && (rb + 18 + i >= rx_q.size() || rx_q[rb + 18 + i] !== c_lfsr[i])) first = i;
      checks++;
      if (first >= 0) begin
         errors++; $display("FAIL lfsr_start: payload byte %0d got %h expected %h", first,
                            (rb + 18 + first < rx_q.size()) ? rx_q[rb + 18 + first] : 8'h00, c_lfsr[first]);
      end
      checks++;
      if (gap_q.size() != gb + 2 || gap_q[gb] != 12 || gap_q[gb + 1] != 12) begin
         errors++; $display("FAIL lfsr_gap: got %0d gaps first=%0d expected 2 gaps of 12",
                            gap_q.size() - gb, (gap_q.size() > gb) ? gap_q[gb] : -1);
      end
      checks++;
      if (fs_q.size() - fb != 3 || frames_sent !== 32'd5) begin
         errors++; $display("FAIL lfsr_count: got pulses=%0d frames=%0d expected 3 5", fs_q.size() - fb, frames_sent);
      end
   endtask

   task automatic test_clamp;
      int rb, hb, db, n, first;
      bit ok1, ok2;
      logic [7:0] e, got, exp_b;
      hold_target = 1; ack_always = 1;
      rb = rx_q.size(); hb = hi_q.size(); db = dn_q.size();
      push_frame(60, 32'd0, 2'd1);
      kick(20, 1, 1, 2'd1, 0);
      wait_done(db, 300, ok1);
      push_frame(1514, 32'd0, 2'd1);
      kick(2000, 1, 1, 2'd1, 0);
      wait_done(db + 1, 2500, ok2);
      checks++;
      if (!(ok1 && ok2)) begin errors++; $display("FAIL clamp_timeout: got %b%b expected 11", ok1, ok2); end
      n = 0; first = -1; got = 8'h00; exp_b = 8'h00;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (first < 0 && (rb + n >= rx_q.size() || rx_q[rb + n] !== e)) begin
            first = n; exp_b = e; got = (rb + n < rx_q.size()) ? rx_q[rb + n] : 8'h00;
         end
         n++;
      end
      checks++;
      if (first >= 0 || rx_q.size() - rb != n) begin
         errors++;
         $display("FAIL clamp_bytes: byte %0d got %h expected %h (count %0d vs %0d)", first, got, exp_b, rx_q.size() - rb, n);
      end
      checks++;
      if (hi_q.size() != hb + 2 || hi_q[hb] != 60 || hi_q[hb + 1] != 1514) begin
         errors++; $display("FAIL clamp_len: got %0d/%0d expected 60/1514",
                            (hi_q.size() > hb) ? hi_q[hb] : -1, (hi_q.size() > hb + 1) ? hi_q[hb + 1] : -1);
      end
      checks++;
      if (frames_sent !== 32'd7) begin errors++; $display("FAIL clamp_count: got %0d expected 7", frames_sent); end
   endtask

   task automatic test_stop;
      int rb, hb, db, n, first, rx_end;
      bit ok;
      logic [7:0] e, got, exp_b;
      hold_target = 1; ack_always = 1;
      rb = rx_q.size(); hb = hi_q.size(); db = dn_q.size();
      push_frame(100, 32'd0, 2'd1);
      push_frame(100, 32'd1, 2'd1);
      kick(100, 5, 0, 2'd1, 0);
      repeat (20) @(negedge tx_clk);
      cfg_len = 14'd60; cfg_mode = 2'd0; cfg_count = 16'd1; start = 1'b1;
      @(negedge tx_clk);
      start = 1'b0;
      for (int i = 0; i < 300 && hi_q.size() <= hb; i++) @(negedge tx_clk);
      for (int i = 0; i < 50 && !mac_tx_dvld; i++) @(negedge tx_clk);
      repeat (30) @(negedge tx_clk);
      stop = 1'b1;
      @(negedge tx_clk);
      stop = 1'b0;
      wait_done(db, 300, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL stop_timeout: got no done expected done"); end
      rx_end = rx_q.size();
      repeat (50) @(negedge tx_clk);
      n = 0; first = -1; got = 8'h00; exp_b = 8'h00;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (first < 0 && (rb + n >= rx_q.size() || rx_q[rb + n] !== e)) begin
            first = n; exp_b = e; got = (rb + n < rx_q.size()) ? rx_q[rb + n] : 8'h00;
         end
         n++;
      end
      checks++;
      if (first >= 0 || rx_q.size() - rb != n) begin
         errors++;
         $display("FAIL stop_bytes: byte %0d got %h expected %h (count %0d vs %0d)", first, got, exp_b, rx_q.size() - rb, n);
      end
      checks++;
      if (hi_q.size() != hb + 2 || hi_q[hb + 1] != 100) begin
         errors++; $display("FAIL stop_frames: got %0d frames expected 2 full frames", hi_q.size() - hb);
      end
      checks++;
      if (rx_q.size() != rx_end || busy !== 1'b0 || mac_tx_dvld !== 1'b0 || frames_sent !== 32'd9) begin
         errors++; $display("FAIL stop_quiet: got extra=%0d busy=%b dvld=%b frames=%0d expected 0 0 0 9",
                            rx_q.size() - rx_end, busy, mac_tx_dvld, frames_sent);
      end
   endtask

   task automatic test_start_stop_ifg;
      int rb, hb, db, n, first;
      logic [7:0] e, got, exp_b;
      hold_target = 1; ack_always = 0;
      rb = rx_q.size(); hb = hi_q.size(); db = dn_q.size();
      push_frame(60, 32'd0, 2'd0);
      kick(60, 40, 0, 2'd0, 1);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL startstop_busy: got %b expected 1", busy); end
      for (int i = 0; i < 200 && hi_q.size() <= hb; i++) @(negedge tx_clk);
      repeat (3) @(negedge tx_clk);
      checks++;
      if (busy !== 1'b1 || dn_q.size() != db) begin
         errors++; $display("FAIL startstop_ignored: got busy=%b dones=%0d expected 1 0", busy, dn_q.size() - db);
      end
      stop = 1'b1;
      @(negedge tx_clk);
      stop = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL ifg_stop: got done=%b busy=%b expected 1 0", done, busy);
      end
      repeat (60) @(negedge tx_clk);
      n = 0; first = -1; got = 8'h00; exp_b = 8'h00;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (first < 0 && (rb + n >= rx_q.size() || rx_q[rb + n] !== e)) begin
            first = n; exp_b = e; got = (rb + n < rx_q.size()) ? rx_q[rb + n] : 8'h00;
         end
         n++;
      end
      checks++;
      if (first >= 0 || rx_q.size() - rb != n || frames_sent !== 32'd10) begin
         errors++;
         $display("FAIL ifg_stop_bytes: byte %0d got %h expected %h (count %0d vs %0d, frames %0d vs 10)",
                  first, got, exp_b, rx_q.size() - rb, n, frames_sent);
      end
   endtask

   task automatic test_reset_mid;
      int rb, db, n, first;
      bit ok;
      logic [7:0] e, got, exp_b;
      hold_target = 1; ack_always = 1;
      kick(200, 1, 0, 2'd1, 0);
      repeat (50) @(negedge tx_clk);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (mac_tx_dvld !== 1'b0 || mac_tx_data !== 8'h00 || busy !== 1'b0 || frames_sent !== 32'd0) begin
         errors++; $display("FAIL async_reset: got dvld=%b data=%h busy=%b frames=%0d expected 0 00 0 0",
                            mac_tx_dvld, mac_tx_data, busy, frames_sent);
      end
      @(negedge tx_clk);
      reset_n = 1'b1;
      @(negedge tx_clk);
      rb = rx_q.size(); db = dn_q.size();
      push_frame(60, 32'd0, 2'd1);
      kick(60, 1, 1, 2'd1, 0);
      wait_done(db, 300, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL restart_timeout: got no done expected done"); end
      n = 0; first = -1; got = 8'h00; exp_b = 8'h00;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (first < 0 && (rb + n >= rx_q.size() || rx_q[rb + n] !== e)) begin
            first = n; exp_b = e; got = (rb + n < rx_q.size()) ? rx_q[rb + n] : 8'h00;
         end
         n++;
      end
      checks++;
      if (first >= 0 || rx_q.size() - rb != n || frames_sent !== 32'd1) begin
         errors++;
         $display("FAIL restart_bytes: byte %0d got %h expected %h (count %0d vs %0d, frames %0d vs 1)",
                  first, got, exp_b, rx_q.size() - rb, n, frames_sent);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ack_delay();
      test_lfsr_burst();
      test_clamp();
      test_stop();
      test_start_stop_ifg();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
